// File: rtl/rv_pkg.sv
// Shared constants and types for the rv front end.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } t_fetch_entry;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instruction} entries; flush overrides push and pop.
module rv_fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  t_fetch_entry           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output t_fetch_entry           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);

    t_fetch_entry  mem_q [DEPTH];
    t_fetch_entry  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch stage: credit-limited sequential imem reads, in-order response queue,
// ready/valid handoff to decode, and redirect flush with stale-response dropping.
module rv_fetch
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_Q100H,
    input  logic        imem_req_ready_Q100H,
    output logic [31:0] imem_addr_Q100H,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_Q102H,
    input  logic [31:0] redirect_pc_Q102H,
    input  logic        ready_Q101H,
    output logic        valid_Q101H,
    output logic [31:0] pc_Q101H,
    output logic [31:0] instruction_Q101H
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_empty, fifo_full;
    logic [FCNT_W-1:0] fifo_count;
    t_fetch_entry      fifo_head, fifo_push_data;
    logic              req_accept;
    logic [1:0]        unused_redirect_low;

    assign unused_redirect_low = redirect_pc_Q102H[1:0];
    assign fifo_push_data      = '{pc: resp_pc_q, instr: imem_rsp_data};
    assign imem_addr_Q100H     = fetch_pc_q;
    assign req_accept          = imem_req_valid_Q100H && imem_req_ready_Q100H;

    assign valid_Q101H       = !fifo_empty;
    assign pc_Q101H          = fifo_empty ? 32'h0 : fifo_head.pc;
    assign instruction_Q101H = fifo_empty ? NOP_INSTR : fifo_head.instr;

    // Every accepted request reserves a queue slot so a response always finds room.
    always_comb begin
        imem_req_valid_Q100H = !rst && !redirect_Q102H && !fifo_full
                             && (int'(outstanding_q) < MAX_OUTSTANDING)
                             && ((int'(outstanding_q) + int'(fifo_count)) < FIFO_DEPTH);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        if (redirect_Q102H) begin
            fetch_pc_d    = {redirect_pc_Q102H[31:2], 2'b00};
            resp_pc_d     = {redirect_pc_Q102H[31:2], 2'b00};
            fifo_flush    = 1'b1;
            outstanding_d = outstanding_q - CNT_W'(imem_rsp_valid);
            // Already-dropping requests are still counted in outstanding, so every
            // request left in flight after this cycle is stale.
            drop_cnt_d    = outstanding_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CNT_W'(req_accept) - CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            fifo_pop = valid_Q101H && ready_Q101H;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    rv_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .flush    (fifo_flush),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule
